video_stream_sink: RTL and testbench
====================================

// Module: video_stream_sink
// PURPOSE
//  Consumer end of the aligned pixel stream: takes line bursts (data/valid) and end-of-frame
//  pulse (vs) produced on video_clk, buffers them in a two-bank ping-pong line buffer, and
//  drives a free-running display raster (DE/HS/VS + RGB888) toward the HDMI/LCD encoder.
//  Detects frame misalignment, line underflow and buffer overflow; resyncs on the next vs.
// PARAMETERS
//  H_DISP 1280 active pixels/line;  H_FP 110;  H_SYNC 40;  H_BP 220  (H_TOTAL = sum)
//  V_DISP 720  active lines/frame;  V_FP 5;    V_SYNC 5;   V_BP 20   (V_TOTAL = sum)
//  HS_POL 1  sync polarity (1 = active-high);  VS_POL 1  same for vsync
// PORTS
//  video_clk  in  1   pixel clock; all logic in this domain
//  rst        in  1   asynchronous, active-high reset
//  in_data    in  16  RGB565 pixel {R5,G6,B5}
//  in_valid   in  1   in_data valid this cycle; bursts of H_DISP per line, no backpressure
//  in_vs      in  1   1-cycle pulse after last pixel of a frame
//  out_de     out 1   active video
//  out_hs     out 1   horizontal sync (polarity HS_POL)
//  out_vs     out 1   vertical sync (polarity VS_POL)
//  out_rgb    out 24  {R8,G8,B8}
//  locked     out 1   1 while in RUN
//  underflow  out 1   sticky: active line started with no full bank in RUN
//  overflow   out 1   sticky: in_valid while write bank still full
// BEHAVIOUR
//  Reset: out_de=0, out_hs=~HS_POL, out_vs=~VS_POL, out_rgb=0, locked/underflow/overflow=0;
//   h_cnt=v_cnt=0, wr_x=wr_line=0, wr_bank=rd_bank=0, bank_full=2'b00, state=SEARCH.
//  Timing: h_cnt 0..H_TOTAL-1 wraps, v_cnt increments on h wrap, 0..V_TOTAL-1; free-runs in all
//   states. Active: h<H_DISP && v<V_DISP. HS asserted for h in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC);
//   VS asserted for v in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC). All outputs registered, fixed
//   2-cycle latency from counters (RAM read + output reg); de/hs/vs/rgb mutually aligned.
//  Write side: in_valid and state!=SEARCH: if bank_full[wr_bank], drop pixel, set overflow;
//   else ram[wr_bank][wr_x]<=in_data, wr_x++; on write of wr_x==H_DISP-1: set
//   bank_full[wr_bank], toggle wr_bank, wr_x=0, wr_line++.
//  Read side: at h_cnt==H_TOTAL-1 preceding an active line: line_ok=(state==RUN &&
//   bank_full[rd_bank]); RUN && !line_ok sets underflow. During active h, read
//   ram[rd_bank][h_cnt]. At h_cnt==H_DISP-1 of a line_ok line: clear bank_full[rd_bank],
//   toggle rd_bank. line_ok=0 -> out_rgb=0 with out_de still per timing.
//  Writer sets and reader clears never target the same bank in one cycle (writer only fills
//   a non-full bank, reader only drains a full one); both in one cycle on different banks OK.
//  FSM: SEARCH: writes ignored; in_vs -> ARM.
//   ARM: on entry clear bank_full, wr_x, wr_line, wr_bank, rd_bank; writes enabled; when
//    h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1 -> RUN (first active line of next frame uses bank0).
//   RUN: locked=1. in_vs with wr_x==0 && wr_line==V_DISP -> wr_line=0, stay. in_vs otherwise
//    (short/long frame or mid-line) -> ARM. wr_line overflowing V_DISP (V_DISP+1 lines) -> ARM.
//  in_vs coincident with in_valid: pixel written first, then vs rules use updated wr_x/wr_line.
//  RGB565->888: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
//  Reset mid-frame: all state to reset values immediately; stickies cleared only by rst.
// TESTING (small params: H_DISP=8,H_FP=2,H_SYNC=2,H_BP=2,V_DISP=4,V_FP=1,V_SYNC=1,V_BP=1)
//  1 Timing only, no input -> DE high 8 clk/line, 4 lines/frame; HS 2 clk at h=10..11; VS
//    on v=5; period 14x7 clk; rgb=0; locked=0.
//  2 in_vs, then 4 lines of 0xFFFF,0xF800,0x07E0,0x001F,... each line written before its
//    active slot -> locked=1; out_rgb FFFFFF,FF0000,00FF00,0000FF aligned with DE; no flags.
//  3 In RUN, withhold line 2 -> that line rgb=0 with DE high, underflow=1 and stays 1.
//  4 Send 3 lines with no reads possible (both banks full) -> 3rd line dropped, overflow=1.
//  5 In RUN, in_vs after 3 lines (or with wr_x=5) -> locked drops to 0, ARM, relock at next
//    frame start after following frame; flags unchanged.
//  6 Assert rst mid-line -> all outputs at reset values next edge; state SEARCH; flags 0.

Source files
------------

// File: rtl/video_stream_sink.sv
// Display end of the aligned pixel stream: a two-bank ping-pong line buffer feeds a free-running
// DE/HS/VS raster. The block relocks to the producer on in_vs and keeps sticky underflow/overflow flags.
module video_stream_sink #(
  parameter int H_DISP = 1280,
  parameter int H_FP   = 110,
  parameter int H_SYNC = 40,
  parameter int H_BP   = 220,
  parameter int V_DISP = 720,
  parameter int V_FP   = 5,
  parameter int V_SYNC = 5,
  parameter int V_BP   = 20,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic        video_clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_vs,
  output logic        out_de,
  output logic        out_hs,
  output logic        out_vs,
  output logic [23:0] out_rgb,
  output logic        locked,
  output logic        underflow,
  output logic        overflow
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = (H_DISP > 1) ? $clog2(H_DISP) : 1;
  localparam int LW      = $clog2(V_DISP + 2);

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DISP_C    = HW'(H_DISP);
  localparam logic [HW-1:0] H_DISP_LAST = HW'(H_DISP - 1);
  localparam logic [HW-1:0] HS_START    = HW'(H_DISP + H_FP);
  localparam logic [HW-1:0] HS_END      = HW'(H_DISP + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DISP_C    = VW'(V_DISP);
  localparam logic [VW-1:0] V_DISP_LAST = VW'(V_DISP - 1);
  localparam logic [VW-1:0] VS_START    = VW'(V_DISP + V_FP);
  localparam logic [VW-1:0] VS_END      = VW'(V_DISP + V_FP + V_SYNC);
  localparam logic [XW-1:0] X_LAST      = XW'(H_DISP - 1);
  localparam logic [LW-1:0] FRAME_LINES = LW'(V_DISP);

  typedef enum logic [1:0] {SEARCH, ARM, RUN} state_t;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  state_t          state, state_nxt;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic [XW-1:0]   wr_x, wr_x_upd;
  logic [LW-1:0]   wr_line, wr_line_upd;
  logic            wr_bank, rd_bank;
  logic [1:0]      bank_full, bank_full_nxt;
  logic            line_ok;
  logic [15:0]     ram [2][H_DISP];
  logic [15:0]     rd_data;
  logic            de_p, hs_p, vs_p, rgb_en_p;

  logic line_end, frame_end, active, next_line_active, hs_act, vs_act;
  logic wr_en, wr_drop, wr_do, wr_line_done, vs_aligned, rd_line_end;
  logic arm_entry, vs_rearm, run_nxt, line_starved;

  // Raster counters free-run in every state so the display never loses timing.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    line_end         = (h_cnt == H_LAST);
    frame_end        = line_end && (v_cnt == V_LAST);
    active           = (h_cnt < H_DISP_C) && (v_cnt < V_DISP_C);
    next_line_active = (v_cnt == V_LAST) || (v_cnt < V_DISP_LAST);
    hs_act           = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_act           = (v_cnt >= VS_START) && (v_cnt < VS_END);

    wr_en        = in_valid && (state != SEARCH);
    wr_drop      = wr_en && bank_full[wr_bank];
    wr_do        = wr_en && !bank_full[wr_bank];
    wr_line_done = wr_do && (wr_x == X_LAST);
    wr_x_upd     = wr_line_done ? '0 : (wr_do ? wr_x + 1'b1 : wr_x);
    wr_line_upd  = wr_line_done ? wr_line + 1'b1 : wr_line;
    // A frame is aligned when in_vs lands exactly after the last pixel of the last line.
    vs_aligned   = (wr_x_upd == '0) && (wr_line_upd == FRAME_LINES);

    rd_line_end  = line_ok && (h_cnt == H_DISP_LAST);

    bank_full_nxt = bank_full;
    if (wr_line_done) bank_full_nxt[wr_bank] = 1'b1;
    if (rd_line_end)  bank_full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) state <= SEARCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SEARCH: if (in_vs) state_nxt = ARM;
      ARM:    if (frame_end) state_nxt = RUN;
      RUN: begin
        if (wr_line_done && (wr_line == FRAME_LINES)) state_nxt = ARM;
        else if (in_vs && !vs_aligned)                state_nxt = ARM;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    arm_entry = (state_nxt == ARM) && (state != ARM);
    vs_rearm  = (state == RUN) && in_vs && (state_nxt == RUN);
    run_nxt   = (state_nxt == RUN);
    // Judged against the state being entered, so the first line after ARM->RUN can display.
    line_starved = line_end && run_nxt && next_line_active && !bank_full[rd_bank];
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      wr_x      <= '0;
      wr_line   <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
      line_ok   <= 1'b0;
    end else if (arm_entry) begin
      wr_x      <= '0;
      wr_line   <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
      line_ok   <= 1'b0;
    end else begin
      wr_x      <= wr_x_upd;
      wr_line   <= vs_rearm ? '0 : wr_line_upd;
      bank_full <= bank_full_nxt;
      if (wr_line_done) wr_bank <= ~wr_bank;
      if (rd_line_end)  rd_bank <= ~rd_bank;
      if (line_end)     line_ok <= run_nxt && next_line_active && bank_full[rd_bank];
    end
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      locked    <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      locked    <= run_nxt;
      underflow <= underflow | line_starved;
      overflow  <= overflow | wr_drop;
    end
  end

  // NOTE: the line buffer has no reset; its contents are only shown once a bank is marked full.
  always_ff @(posedge video_clk) begin
    if (wr_do) ram[wr_bank][wr_x] <= in_data;
    rd_data <= ram[rd_bank][h_cnt[XW-1:0]];
  end

  // Stage 1 runs alongside the RAM read; stage 2 drives the pins so de/hs/vs/rgb stay aligned.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      de_p     <= 1'b0;
      hs_p     <= 1'b0;
      vs_p     <= 1'b0;
      rgb_en_p <= 1'b0;
      out_de   <= 1'b0;
      out_hs   <= ~HS_POL;
      out_vs   <= ~VS_POL;
      out_rgb  <= '0;
    end else begin
      de_p     <= active;
      hs_p     <= hs_act;
      vs_p     <= vs_act;
      rgb_en_p <= active && line_ok;
      out_de   <= de_p;
      out_hs   <= hs_p ? HS_POL : ~HS_POL;
      out_vs   <= vs_p ? VS_POL : ~VS_POL;
      out_rgb  <= rgb_en_p ? rgb565_to_888(rd_data) : 24'h0;
    end
  end

endmodule

// File: tb/tb_video_stream_sink.sv
// Bench for video_stream_sink on a small raster: a queue-based model of the line buffer and a
// cycle-count raster predict every output, compared each clock while directed phases run.
module tb_video_stream_sink;

  localparam int H_DISP = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
  localparam int V_DISP = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  logic        video_clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_vs;
  logic        out_de, out_hs, out_vs;
  logic [23:0] out_rgb;
  logic        locked, underflow, overflow;

  always #5 video_clk = ~video_clk;

  video_stream_sink #(
    .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .video_clk(video_clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_vs(in_vs),
    .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs), .out_rgb(out_rgb),
    .locked(locked), .underflow(underflow), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] to888(input logic [15:0] p);
    logic [7:0] r, g, b;
    r = {p[15:11], p[15:13]};
    g = {p[10:5], p[10:9]};
    b = {p[4:0], p[4:2]};
    return {r, g, b};
  endfunction

  typedef enum int {M_SEARCH, M_ARM, M_RUN} mstate_t;
  typedef struct packed {logic de; logic hs; logic vs; logic [23:0] rgb;} pix_t;

  // Model: completed lines sit in a FIFO (at most two); the partial line is collected apart.
  mstate_t     m_state;
  int          m_c;
  int          m_wr_line;
  bit          m_line_ok, m_under, m_over;
  logic [15:0] m_full_q[$];
  logic [15:0] m_part_q[$];
  pix_t        m_exp_q[$];
  logic [15:0] bars [4] = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F};

  task automatic model_reset();
    pix_t idle;
    idle = '0;
    m_state = M_SEARCH;
    m_c = 0;
    m_wr_line = 0;
    m_line_ok = 0;
    m_under = 0;
    m_over = 0;
    m_full_q.delete();
    m_part_q.delete();
    m_exp_q.delete();
    m_exp_q.push_back(idle);
  endtask

  task automatic tick(input logic valid, input logic [15:0] data, input logic vs);
    int h, v, n_full, upd_x, upd_line;
    bit drop, done, do_pop, nxt_active, new_ok;
    pix_t p;
    mstate_t nxt;
    in_valid = valid;
    in_data  = data;
    in_vs    = vs;
    h = m_c % H_TOTAL;
    v = (m_c / H_TOTAL) % V_TOTAL;
    n_full = m_full_q.size() / H_DISP;

    p.de  = (h < H_DISP) && (v < V_DISP);
    p.hs  = (h >= H_DISP + H_FP) && (h < H_DISP + H_FP + H_SYNC);
    p.vs  = (v >= V_DISP + V_FP) && (v < V_DISP + V_FP + V_SYNC);
    p.rgb = 24'h0;
    if (p.de && m_line_ok) p.rgb = to888(m_full_q[h]);
    m_exp_q.push_back(p);

    drop = 0;
    done = 0;
    if (valid && m_state != M_SEARCH) begin
      if (n_full == 2) drop = 1;
      else begin
        m_part_q.push_back(data);
        done = (m_part_q.size() == H_DISP);
      end
    end
    upd_x    = done ? 0 : m_part_q.size();
    upd_line = m_wr_line + (done ? 1 : 0);
    do_pop   = m_line_ok && (h == H_DISP - 1);

    nxt = m_state;
    case (m_state)
      M_SEARCH: if (vs) nxt = M_ARM;
      M_ARM:    if (h == H_TOTAL - 1 && v == V_TOTAL - 1) nxt = M_RUN;
      default: begin
        if (done && m_wr_line == V_DISP) nxt = M_ARM;
        else if (vs && !(upd_x == 0 && upd_line == V_DISP)) nxt = M_ARM;
      end
    endcase

    nxt_active = ((v + 1) % V_TOTAL) < V_DISP;
    new_ok = (nxt == M_RUN) && nxt_active && (n_full >= 1);
    if (h == H_TOTAL - 1 && nxt == M_RUN && nxt_active && n_full == 0) m_under = 1;
    if (drop) m_over = 1;

    if (do_pop) for (int i = 0; i < H_DISP; i++) void'(m_full_q.pop_front());
    if (done) begin
      for (int i = 0; i < H_DISP; i++) m_full_q.push_back(m_part_q[i]);
      m_part_q.delete();
    end
    m_wr_line = (m_state == M_RUN && nxt == M_RUN && vs) ? 0 : upd_line;
    if (h == H_TOTAL - 1) m_line_ok = new_ok;
    if (nxt == M_ARM && m_state != M_ARM) begin
      m_full_q.delete();
      m_part_q.delete();
      m_wr_line = 0;
      m_line_ok = 0;
    end
    m_state = nxt;
    m_c++;

    @(posedge video_clk);
    #1;
    p = m_exp_q.pop_front();
    check($sformatf("de@%0d", m_c), out_de, p.de);
    check($sformatf("hs@%0d", m_c), out_hs, p.hs);
    check($sformatf("vs@%0d", m_c), out_vs, p.vs);
    check($sformatf("rgb@%0d", m_c), out_rgb, p.rgb);
    check($sformatf("locked@%0d", m_c), locked, (m_state == M_RUN));
    check($sformatf("underflow@%0d", m_c), underflow, m_under);
    check($sformatf("overflow@%0d", m_c), overflow, m_over);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 1'b0);
  endtask

  task automatic wait_pos(input int v, input int h);
    int n;
    n = 0;
    while (!((m_c % H_TOTAL) == h && ((m_c / H_TOTAL) % V_TOTAL) == v) && n < H_TOTAL * V_TOTAL) begin
      tick(1'b0, 16'h0, 1'b0);
      n++;
    end
  endtask

  // One producer frame starting at raster v=V_TOTAL-1,h=0: each line is pushed during the
  // raster line before its own display slot.
  task automatic stream_frame(input int n_lines, input int skip, input int vs_line,
                              input int vs_h, input bit use_bars);
    logic        valid, vs;
    logic [15:0] d;
    for (int s = 0; s < n_lines; s++) begin
      for (int h = 0; h < H_TOTAL; h++) begin
        valid = (s != skip) && (h < H_DISP);
        vs    = (s == vs_line) && (h == vs_h);
        d     = use_bars ? bars[h % 4] : 16'($urandom);
        tick(valid, valid ? d : 16'h0, vs);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_de"}, out_de, 1'b0);
    check({tag, "_hs"}, out_hs, 1'b0);
    check({tag, "_vs"}, out_vs, 1'b0);
    check({tag, "_rgb"}, out_rgb, 24'h0);
    check({tag, "_locked"}, locked, 1'b0);
    check({tag, "_underflow"}, underflow, 1'b0);
    check({tag, "_overflow"}, overflow, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    in_data = 16'h0;
    in_valid = 1'b0;
    in_vs = 1'b0;
    #2 rst = 1'b1;
    #6 check_reset_outputs("reset");
    repeat (2) @(posedge video_clk);
    @(negedge video_clk);
    rst = 1'b0;
    model_reset();

    // Raster alone: two frames with no input.
    idle(2 * H_TOTAL * V_TOTAL);
    check("idle_locked", locked, 1'b0);

    // Lock, then two frames of colour bars and random pixels written just ahead of display.
    wait_pos(V_DISP + V_FP, 0);
    tick(1'b0, 16'h0, 1'b1);
    wait_pos(V_TOTAL - 1, 0);
    stream_frame(V_DISP, -1, V_DISP - 1, H_DISP, 1'b1);
    wait_pos(V_TOTAL - 1, 0);
    stream_frame(V_DISP, -1, V_DISP - 1, H_DISP, 1'b0);
    check("run_locked", locked, 1'b1);
    check("run_no_underflow", underflow, 1'b0);
    check("run_no_overflow", overflow, 1'b0);

    // Withhold line 2: blank line with DE, sticky underflow, short frame forces re-arm.
    wait_pos(V_TOTAL - 1, 0);
    stream_frame(V_DISP, 2, V_DISP - 1, H_DISP, 1'b0);
    check("starve_underflow", underflow, 1'b1);
    wait_pos(V_TOTAL - 1, 0);
    stream_frame(V_DISP, -1, V_DISP - 1, H_DISP, 1'b0);
    check("starve_relock", locked, 1'b1);
    check("starve_sticky", underflow, 1'b1);

    // Early in_vs after three lines drops lock; the following frame relocks.
    wait_pos(V_TOTAL - 1, 0);
    stream_frame(V_DISP - 1, -1, V_DISP - 2, H_DISP, 1'b0);
    check("short_unlocked", locked, 1'b0);
    wait_pos(V_TOTAL - 1, 0);
    stream_frame(V_DISP, -1, V_DISP - 1, H_DISP, 1'b0);
    check("short_relock", locked, 1'b1);
    check("short_no_overflow", overflow, 1'b0);

    // Re-arm mid-frame, then three back-to-back lines with no reader: third one overflows.
    tick(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 3 * H_DISP; i++) tick(1'b1, 16'($urandom), 1'b0);
    check("burst_overflow", overflow, 1'b1);
    wait_pos(V_TOTAL - 1, 0);
    idle(H_TOTAL * V_TOTAL);

    // Asynchronous reset in the middle of an active line.
    wait_pos(1, 3);
    #3 rst = 1'b1;
    #1 check_reset_outputs("midreset");
    @(posedge video_clk);
    #1 check_reset_outputs("midreset_hold");
    @(negedge video_clk);
    rst = 1'b0;
    model_reset();
    idle(H_TOTAL * V_TOTAL + 5);
    check("post_reset_locked", locked, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
